// File: rtl/a_memory_stage_if.sv
// a_memory_stage_if: EX/MEM bundle, data-cache handshake, snoop and MEM/WB bundle of the memory stage
interface a_memory_stage_if;
    logic        ex_valid, ex_MemRead, ex_MemWrite, ex_LL, ex_SC, ex_RegWEN, ex_halt;
    logic [31:0] ex_port_o, ex_store_data, ex_NPC, ex_Imm_Ext;
    logic [1:0]  ex_MemtoReg;
    logic [4:0]  ex_Rw;
    logic        dREN, dWEN, dhit;
    logic [31:0] daddr, dstore, dmemload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        mem_stall;
    logic        wb_valid, wb_RegWEN, wb_halt;
    logic [31:0] wb_port_o, wb_NPC, wb_dmemload, wb_Imm_Ext;
    logic [1:0]  wb_MemtoReg;
    logic [4:0]  wb_Rw;
    modport slave (
        input  ex_valid, ex_MemRead, ex_MemWrite, ex_LL, ex_SC, ex_RegWEN, ex_halt,
               ex_port_o, ex_store_data, ex_NPC, ex_Imm_Ext, ex_MemtoReg, ex_Rw,
               dhit, dmemload, snoop_inv, snoop_addr,
        output dREN, dWEN, daddr, dstore, mem_stall,
               wb_valid, wb_RegWEN, wb_halt, wb_port_o, wb_NPC, wb_dmemload, wb_Imm_Ext,
               wb_MemtoReg, wb_Rw
    );
    modport master (
        output ex_valid, ex_MemRead, ex_MemWrite, ex_LL, ex_SC, ex_RegWEN, ex_halt,
               ex_port_o, ex_store_data, ex_NPC, ex_Imm_Ext, ex_MemtoReg, ex_Rw,
               dhit, dmemload, snoop_inv, snoop_addr,
        input  dREN, dWEN, daddr, dstore, mem_stall,
               wb_valid, wb_RegWEN, wb_halt, wb_port_o, wb_NPC, wb_dmemload, wb_Imm_Ext,
               wb_MemtoReg, wb_Rw
    );
endinterface

// File: rtl/a_memory_stage.sv
// a_memory_stage: MEM pipeline stage with data-cache handshake, LL/SC link tracking and MEM/WB register
module a_memory_stage (
    input logic CLK,
    input logic nRST,
    a_memory_stage_if.slave m
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
    typedef struct packed {
        logic        valid;
        logic        RegWEN;
        logic        halt;
        logic [31:0] port_o;
        logic [31:0] NPC;
        logic [31:0] dmemload;
        logic [31:0] Imm_Ext;
        logic [1:0]  MemtoReg;
        logic [4:0]  Rw;
    } wb_t;
    state_t      state_q, state_d;
    wb_t         wb_q, wb_d;
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic [31:0] daddr, snoop_word;
    logic        sc_go, memop, run, rd, wr, stall, done, halt_now;
    assign daddr      = m.ex_port_o & 32'hFFFF_FFFC;
    assign snoop_word = m.snoop_addr & 32'hFFFF_FFFC;
    assign sc_go      = m.ex_SC & link_valid_q & (link_addr_q == daddr);
    assign memop      = m.ex_valid & (m.ex_MemRead | m.ex_MemWrite | m.ex_LL | sc_go);
    assign run        = state_q != HALTED;
    assign rd         = run & memop & (m.ex_MemRead | m.ex_LL);
    assign wr         = run & memop & (m.ex_MemWrite | sc_go) & !rd;
    assign stall      = run & memop & !m.dhit;
    assign done       = run & !stall & m.ex_valid;
    assign halt_now   = done & m.ex_halt;
    // Request outputs drop the instant reset asserts, abandoning any pending access
    assign m.daddr     = daddr;
    assign m.dstore    = m.ex_store_data;
    assign m.dREN      = rd & nRST;
    assign m.dWEN      = wr & nRST;
    assign m.mem_stall = stall & nRST;
    always_comb begin
        state_d      = state_q;
        wb_d         = wb_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (stall) begin
            state_d     = WAIT;
            wb_d.valid  = 1'b0;
            wb_d.RegWEN = 1'b0;
        end else if (run) begin
            state_d = halt_now ? HALTED : (m.dhit ? IDLE : state_q);
            wb_d = '{valid: m.ex_valid & !halt_now, RegWEN: m.ex_RegWEN & !halt_now, halt: halt_now,
                     port_o: m.ex_SC ? {31'd0, sc_go} : m.ex_port_o, NPC: m.ex_NPC,
                     dmemload: m.dmemload, Imm_Ext: m.ex_Imm_Ext,
                     MemtoReg: m.ex_SC ? 2'd0 : m.ex_MemtoReg, Rw: m.ex_Rw};
        end
        if ((done & (m.ex_SC | (m.ex_MemWrite & (daddr == link_addr_q)))) |
            (m.snoop_inv & (snoop_word == link_addr_q)))
            link_valid_d = 1'b0;
        // A completing LL wins over a same-cycle invalidate of its own word
        if (done & m.ex_LL) begin
            link_valid_d = 1'b1;
            link_addr_d  = daddr;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            wb_q         <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            wb_q         <= wb_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
    assign m.wb_valid    = wb_q.valid;
    assign m.wb_RegWEN   = wb_q.RegWEN;
    assign m.wb_halt     = wb_q.halt;
    assign m.wb_port_o   = wb_q.port_o;
    assign m.wb_NPC      = wb_q.NPC;
    assign m.wb_dmemload = wb_q.dmemload;
    assign m.wb_Imm_Ext  = wb_q.Imm_Ext;
    assign m.wb_MemtoReg = wb_q.MemtoReg;
    assign m.wb_Rw       = wb_q.Rw;
endmodule
